// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker family.
//   - tt_state_e     : sweep FSM states (also exported on the debug port)
//   - N_VEC / CNT_W  : vector count and settle-counter width for the
//                      default configuration (N_IN=2, SETTLE=5)
//   - expected_entry : extracts one truth-table row from a packed table
package tt_pkg;

    localparam int unsigned N_IN_DEF   = 2;
    localparam int unsigned SETTLE_DEF = 5;
    localparam int unsigned N_VEC      = 2 ** N_IN_DEF;
    localparam int unsigned CNT_W      = $clog2(SETTLE_DEF + 1);

    // Largest table supported: 64 vectors x 8 outputs.
    localparam int unsigned TABLE_MAX_W = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } tt_state_e;

    // Row i of the table occupies bits [i*n_out +: n_out]; unused upper
    // result bits are returned as zero.
    function automatic logic [7:0] expected_entry(
        input logic [TABLE_MAX_W-1:0] tbl,
        input int unsigned            index,
        input int unsigned            n_out
    );
        logic [7:0] r;
        r = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            if (b < n_out) begin
                r[b] = tbl[index * n_out + b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Bundle between the checker and the lab DUT / status LEDs.
//   START      : begin a sweep (sampled only when not busy)
//   STIM       : DUT input vector, MSB is input A
//   RESP       : DUT output vector, MSB is output X
//   BUSY/DONE  : sweep in progress / results valid
//   PASS       : no mismatches in the last sweep (valid with DONE)
//   ERR_COUNT  : mismatching vectors in the last sweep
//   FIRST_FAIL : index of the first mismatching vector (0 if none)
//   STATE_DBG  : current FSM state, for checkers and debug
// START is a level-sampled request: it is accepted on a rising edge where
// the checker is in IDLE or FINISH, and ignored on every other edge; there
// is no ready/ack beyond BUSY going high on the following cycle.
interface tt_if #(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned N_OUT = 2
);
    import tt_pkg::*;

    logic              START;
    logic [N_IN-1:0]   STIM;
    logic [N_OUT-1:0]  RESP;
    logic              BUSY;
    logic              DONE;
    logic              PASS;
    logic [N_IN:0]     ERR_COUNT;
    logic [N_IN-1:0]   FIRST_FAIL;
    tt_state_e         STATE_DBG;

    // Checker side.
    modport master (
        input  START, RESP,
        output STIM, BUSY, DONE, PASS, ERR_COUNT, FIRST_FAIL, STATE_DBG
    );

    // DUT / controller side.
    modport slave (
        output START, RESP,
        input  STIM, BUSY, DONE, PASS, ERR_COUNT, FIRST_FAIL, STATE_DBG
    );

endinterface

// File: rtl/truth_table_checker_settle_timer.sv
// Settle timer: counts enabled cycles and flags the last settle cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return count to 0 (wins over enable)
//   enable     : count this cycle
//   expire     : count has reached SETTLE-1
module settle_timer #(
    parameter int unsigned SETTLE = 5,
    parameter int unsigned CNT_W  = $clog2(SETTLE + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_checker.sv
// Truth-table checker: sweeps every input combination of a small
// combinational DUT in ascending order, holds each vector for SETTLE
// cycles, samples the response on one further cycle and compares it with
// the packed EXPECTED table. Results are held until the next sweep.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : tt_if master modport (START/STIM/RESP/results/state)
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SETTLE = 5,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = 8'h68
) (
    input  logic CLK,
    input  logic RST_N,
    tt_if.master bus
);

    localparam int unsigned NUM_VEC = 2 ** N_IN;
    localparam int unsigned TIMER_W = $clog2(SETTLE + 1);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NUM_VEC - 1);

    tt_state_e         state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ff_q, ff_d;

    logic              tmr_clear;
    logic              tmr_en;
    logic              tmr_expire;

    logic [7:0]        exp_full;
    logic [N_OUT-1:0]  exp_row;
    logic              mismatch;

    settle_timer #(
        .SETTLE (SETTLE),
        .CNT_W  (TIMER_W)
    ) u_timer (
        .clk    (CLK),
        .rst_n  (RST_N),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expire (tmr_expire)
    );

    assign exp_full = expected_entry(TABLE_MAX_W'(EXPECTED), 32'(idx_q), N_OUT);
    assign exp_row  = exp_full[N_OUT-1:0];
    assign mismatch = (bus.RESP != exp_row);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stim_d    = stim_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_d     = err_q;
        ff_d      = ff_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;

        case (state_q)
            IDLE, FINISH: begin
                if (bus.START) begin
                    state_d   = WAIT;
                    idx_d     = '0;
                    stim_d    = '0;
                    err_d     = '0;
                    ff_d      = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    tmr_clear = 1'b1;
                end
            end

            WAIT: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                tmr_clear = 1'b1;
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    // err_q still zero means this is the sweep's first miss.
                    if (err_q == '0) begin
                        ff_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = WAIT;
                    idx_d   = idx_q + 1'b1;
                    stim_d  = idx_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    assign bus.STIM       = stim_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.PASS       = pass_q;
    assign bus.ERR_COUNT  = err_q;
    assign bus.FIRST_FAIL = ff_q;
    assign bus.STATE_DBG  = state_q;

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Synthesizable stimulus/response engine for small combinational lab blocks, e.g. 2-in/2-out schematics with inputs A, B and outputs X, Y.
- Walks every input combination in ascending order and drives it onto the DUT inputs.
- After a programmable settle time, samples the DUT outputs and compares them to a parameterised expected truth table.
- Sits beside the DUT on the board or in a top-level wrapper and reports pass/fail on LEDs, with no simulator needed.

Parameters:
- N_IN, 2, number of DUT inputs driven (1..6).
- N_OUT, 2, number of DUT outputs checked (1..8).
- SETTLE, 5, clock cycles STIM is held before RESP is sampled (>=1).
- EXPECTED, 8'h68, packed truth table: entry i at bits [i*N_OUT +: N_OUT]. Default is a half adder with RESP={X,Y}, X=A^B, Y=A&B.

Ports:
- CLK  in  1  single system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  begin a sweep; sampled only in IDLE or FINISH.
- STIM  out  N_IN  DUT input vector; {A,B} for the default, so A is the MSB.
- RESP  in  N_OUT  DUT output vector; {X,Y} for the default.
- BUSY  out  1  high from the cycle after START is accepted until the sweep ends.
- DONE  out  1  high while in FINISH; held until the next accepted START or reset.
- PASS  out  1  valid when DONE=1; 1 iff ERR_COUNT==0.
- ERR_COUNT  out  N_IN+1  number of mismatching vectors in the last sweep.
- FIRST_FAIL  out  N_IN  index of the first mismatching vector; 0 if none.

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets: state=IDLE, STIM=0, BUSY=0, DONE=0, PASS=0, ERR_COUNT=0, FIRST_FAIL=0, index=0, settle counter=0.
- States: IDLE, WAIT, CHECK, FINISH.
- IDLE:
  - START=1 -> WAIT next cycle, with STIM=0, index=0, cnt=0, ERR_COUNT=0, FIRST_FAIL=0, BUSY=1.
- WAIT:
  - Hold STIM=index and increment cnt.
  - When cnt==SETTLE-1 -> CHECK next cycle.
  - WAIT therefore lasts exactly SETTLE cycles per vector.
- CHECK, one cycle:
  - Compare RESP with EXPECTED entry [index].
  - On mismatch, ERR_COUNT+1. If this is the first mismatch of the sweep, FIRST_FAIL=index.
  - If index==2^N_IN-1 -> FINISH.
  - Otherwise index+1, STIM updates on the same edge, cnt=0 -> WAIT.
- FINISH:
  - BUSY=0, DONE=1, PASS=(ERR_COUNT==0).
  - START=1 -> restart exactly as from IDLE (DONE drops on the same edge).
- Latency: START-accept edge to DONE=1 is 2^N_IN*(SETTLE+1) cycles. Defaults give 24.
- START while BUSY=1 is ignored; no restart and no effect on counts.
- STIM changes only on the WAIT-entry edges. Each vector is presented for exactly SETTLE+1 cycles (WAIT plus CHECK), which makes the sample point glitch-safe for combinational DUTs.
- ERR_COUNT cannot overflow, since its maximum is 2^N_IN and fits in N_IN+1 bits.
- Index wrap: the index never wraps inside a sweep. It is reset to 0 only by restart or reset.
- Reset mid-sweep: all outputs immediately return to reset values and STIM=0. Partial results are discarded.
- RESP is treated as synchronous to CLK. The DUT is combinational from STIM, so no synchroniser is needed.

Decomposition:
- Shared package tt_pkg:
  - state enum (IDLE, WAIT, CHECK, FINISH);
  - function expected_entry(table, index, n_out), which returns the slice;
  - localparams N_VEC=2**N_IN and CNT_W=$clog2(SETTLE+1).
- One natural sub-module, settle_timer:
  - inputs: clear, enable;
  - output: expire, asserted when count reaches SETTLE-1;
  - reused by later lab checkers.
- The FSM, comparison and result registers live in truth_table_checker.

Test Plan:
- Reset then START pulse, with a correct half-adder DUT model driving RESP. Required response:
  - STIM sequence 0,1,2,3, each held 6 cycles;
  - DONE=1 at cycle 24 after accept;
  - PASS=1, ERR_COUNT=0, FIRST_FAIL=0.
- Faulty DUT with Y stuck at 0. Required response:
  - DONE at 24;
  - ERR_COUNT=1, FIRST_FAIL=3, PASS=0.
- Faulty DUT with X=A|B. Required response:
  - ERR_COUNT=1, FIRST_FAIL=3, because vector 3 expects 01 and gets 11.
- X inverted on every vector. Required response:
  - ERR_COUNT=4, FIRST_FAIL=0, PASS=0.
- START pulsed again at cycle 10 mid-sweep. Required response:
  - ignored, so the sweep still ends at cycle 24 with unchanged counts;
  - START in FINISH restarts: DONE=0 next cycle, ERR_COUNT cleared to 0.
- RST_N asserted low at cycle 13 (during vector 2), asynchronously. Required response:
  - STIM=0, BUSY=0, ERR_COUNT=0 immediately;
  - after release plus START, a full 24-cycle sweep completes with the correct result.
